// File: rtl/spi_crc16_chk.sv
// -----------------------------------------------------------------------------
// spi_crc16_chk
//
// Receives one SPI/SD-style data block from a serial line and checks its
// CRC16. After an accepted start the block waits for a start bit (din=0).
// It then takes blk_len payload bytes, MSB first, through the CRC16/XMODEM
// polynomial (x^16+x^12+x^5+1, seed 0x0000). Next come 16 received CRC bits
// and one end bit, which must be 1. One cycle after the end bit it pulses
// done and presents the status, which holds until the next accepted start,
// an abort or a reset.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start_i     in   single-cycle request to arm reception (ignored if busy)
//   abort_i     in   cancel any reception; wins over start_i
//   blk_len_i   in   [9:0] payload length in bytes, sampled on accepted start
//   din_i       in   serial data bit, MSB first
//   din_vld_i   in   din_i qualifier, one bit consumed per qualified cycle
//   busy_o      out  high whenever the receiver is not idle
//   done_o      out  one-cycle pulse when a block completes
//   crc_ok_o    out  CRC matched and end bit was 1
//   crc_err_o   out  computed CRC differs from received CRC
//   frm_err_o   out  end bit was 0
//   crc_calc_o  out  [15:0] CRC computed over the payload
//   crc_rcvd_o  out  [15:0] CRC received from the line
// -----------------------------------------------------------------------------
module spi_crc16_chk #(
    parameter int LEN_W = 10,
    parameter int CNT_W = LEN_W + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [LEN_W-1:0] blk_len_i,
    input  logic             din_i,
    input  logic             din_vld_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             crc_ok_o,
    output logic             crc_err_o,
    output logic             frm_err_o,
    output logic [15:0]      crc_calc_o,
    output logic [15:0]      crc_rcvd_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_DATA       = 3'd2,
        S_CRC        = 3'd3,
        S_END        = 3'd4
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [15:0]        crc_calc_q;
    logic [15:0]        crc_rcvd_q;
    logic               done_q;
    logic               crc_ok_q;
    logic               crc_err_q;
    logic               frm_err_q;

    logic [15:0]        crc_calc_d;
    logic [15:0]        crc_rcvd_d;
    logic [CNT_W-1:0]   data_bits_m1;
    logic               last_data_bit;
    logic               last_crc_bit;
    logic               start_ok;

    // One serial step of the CRC16 shift register (feedback from bit 15).
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        bit_in);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        crc_calc_d    = crc16_step(crc_calc_q, din_i);
        crc_rcvd_d    = {crc_rcvd_q[14:0], din_i};
        // Payload length in bits minus one; len_q is never 0 while in DATA.
        data_bits_m1  = {len_q, 3'b000} - CNT_W'(1);
        last_data_bit = (bit_cnt_q == data_bits_m1);
        last_crc_bit  = (bit_cnt_q == CNT_W'(15));
        start_ok      = start_i && (blk_len_i != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            crc_calc_q <= '0;
            crc_rcvd_q <= '0;
            done_q     <= 1'b0;
            crc_ok_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                // Abort overrides everything, including a start in the same cycle.
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
                crc_ok_q  <= 1'b0;
                crc_err_q <= 1'b0;
                frm_err_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // din_vld in this cycle is deliberately not consumed.
                        if (start_ok) begin
                            len_q      <= blk_len_i;
                            bit_cnt_q  <= '0;
                            crc_calc_q <= '0;
                            crc_rcvd_q <= '0;
                            crc_ok_q   <= 1'b0;
                            crc_err_q  <= 1'b0;
                            frm_err_q  <= 1'b0;
                            state_q    <= S_WAIT_START;
                        end
                    end

                    S_WAIT_START: begin
                        // Idle-high line: qualified 1s are discarded.
                        if (din_vld_i && !din_i) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_DATA;
                        end
                    end

                    S_DATA: begin
                        if (din_vld_i) begin
                            crc_calc_q <= crc_calc_d;
                            if (last_data_bit) begin
                                bit_cnt_q <= '0;
                                state_q   <= S_CRC;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    S_CRC: begin
                        if (din_vld_i) begin
                            crc_rcvd_q <= crc_rcvd_d;
                            if (last_crc_bit) begin
                                bit_cnt_q <= '0;
                                state_q   <= S_END;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    S_END: begin
                        if (din_vld_i) begin
                            frm_err_q <= !din_i;
                            crc_err_q <= (crc_calc_q != crc_rcvd_q);
                            crc_ok_q  <= (crc_calc_q == crc_rcvd_q) && din_i;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign crc_ok_o   = crc_ok_q;
    assign crc_err_o  = crc_err_q;
    assign frm_err_o  = frm_err_q;
    assign crc_calc_o = crc_calc_q;
    assign crc_rcvd_o = crc_rcvd_q;

endmodule

// File: tb/tb_spi_crc16_chk.sv
module tb_spi_crc16_chk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [9:0]  blk_len_i = '0;
    logic        din_i = 1'b1;
    logic        din_vld_i = 1'b0;
    logic        busy_o, done_o, crc_ok_o, crc_err_o, frm_err_o;
    logic [15:0] crc_calc_o, crc_rcvd_o;

    spi_crc16_chk dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .blk_len_i  (blk_len_i),
        .din_i      (din_i),
        .din_vld_i  (din_vld_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .crc_ok_o   (crc_ok_o),
        .crc_err_o  (crc_err_o),
        .frm_err_o  (frm_err_o),
        .crc_calc_o (crc_calc_o),
        .crc_rcvd_o (crc_rcvd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] calc;
        logic [15:0] rcvd;
        logic        ok;
        logic        err;
        logic        frm;
    } exp_t;

    exp_t       sb[$];
    exp_t       last_exp;
    logic [7:0] payload[$];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC16/XMODEM, computed byte-wise over the payload queue.
    function automatic logic [15:0] ref_crc();
        int c;
        c = 0;
        foreach (payload[i]) begin
            c = c ^ (int'(payload[i]) << 8);
            for (int k = 0; k < 8; k++) begin
                if ((c & 'h8000) != 0) c = ((c << 1) ^ 'h1021) & 'hFFFF;
                else                   c = (c << 1) & 'hFFFF;
            end
        end
        return c[15:0];
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("crc_calc", 32'(crc_calc_o), 32'(e.calc));
                chk("crc_rcvd", 32'(crc_rcvd_o), 32'(e.rcvd));
                chk("crc_ok",   32'(crc_ok_o),   32'(e.ok));
                chk("crc_err",  32'(crc_err_o),  32'(e.err));
                chk("frm_err",  32'(frm_err_o),  32'(e.frm));
                chk("busy_at_done", 32'(busy_o), 32'd0);
            end
        end
    end

    task automatic send_bit(input logic b, input int gap);
        while ($urandom_range(0, 99) < gap) begin
            din_vld_i = 1'b0;
            din_i     = 1'($urandom_range(0, 1));
            tick();
        end
        din_vld_i = 1'b1;
        din_i     = b;
        tick();
        din_vld_i = 1'b0;
        din_i     = 1'b1;
    endtask

    task automatic do_start(input int len);
        start_i   = 1'b1;
        blk_len_i = 10'(len);
        din_vld_i = 1'b1;   // must not be consumed in the start cycle
        din_i     = 1'b0;
        tick();
        start_i   = 1'b0;
        din_vld_i = 1'b0;
        din_i     = 1'b1;
    endtask

    // Full block from the payload queue; expectation goes to the scoreboard.
    task automatic send_block(input logic [15:0] crc_sent, input logic end_bit,
                              input int pre_ones, input int gap);
        exp_t e;
        e.calc = ref_crc();
        e.rcvd = crc_sent;
        e.err  = (e.calc != crc_sent);
        e.ok   = (e.calc == crc_sent) && end_bit;
        e.frm  = !end_bit;
        do_start(payload.size());
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_clr", {13'd0, crc_ok_o, crc_err_o, frm_err_o, crc_calc_o}, 32'd0);
        sb.push_back(e);
        last_exp = e;
        repeat (pre_ones) send_bit(1'b1, gap);
        send_bit(1'b0, gap);
        foreach (payload[i])
            for (int k = 7; k >= 0; k--) send_bit(payload[i][k], gap);
        for (int k = 15; k >= 0; k--) send_bit(crc_sent[k], gap);
        send_bit(end_bit, gap);
        for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 10 cycles");
            sb.delete();
        end
        repeat (3) tick();
        chk("hold_ok",  32'(crc_ok_o),  32'(e.ok));
        chk("hold_err", 32'(crc_err_o), 32'(e.err));
    endtask

    task automatic basic_block(input logic [15:0] crc_sent, input logic end_bit, input int pre_ones);
        payload.delete();
        payload.push_back(8'h01);
        send_block(crc_sent, end_bit, pre_ones, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        #3;
        chk("rst_outs", {busy_o, done_o, crc_ok_o, crc_err_o, frm_err_o, crc_calc_o, crc_rcvd_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single-byte block with correct CRC.
        basic_block(16'h1021, 1'b1, 0);
        chk("b1_calc_const", 32'(crc_calc_o), 32'h1021);
        // Bad CRC, then bad end bit.
        basic_block(16'h1020, 1'b1, 0);
        basic_block(16'h1021, 1'b0, 0);
        // Leading idle 1s before the start bit.
        basic_block(16'h1021, 1'b1, 5);

        // Zero-length start is ignored; status unchanged.
        start_i = 1'b1; blk_len_i = '0;
        tick();
        start_i = 1'b0;
        chk("len0_busy", 32'(busy_o), 32'd0);
        chk("len0_hold", 32'(crc_ok_o), 32'(last_exp.ok));

        // 512 bytes of 0xFF with gaps.
        payload.delete();
        repeat (512) payload.push_back(8'hFF);
        send_block(16'h7FA1, 1'b1, 0, 30);

        // Randomized blocks.
        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, 16);
            payload.delete();
            repeat (len) payload.push_back(8'($urandom));
            c = ref_crc();
            if ($urandom_range(0, 2) == 0) c = c ^ (16'h1 << $urandom_range(0, 15));
            send_block(c, ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 40));
        end

        // Abort on the 100th DATA bit of a 512-byte block.
        do_start(512);
        send_bit(1'b0, 10);
        repeat (99) send_bit(1'b1, 10);
        abort_i = 1'b1; din_vld_i = 1'b1; din_i = 1'b1;
        tick();
        abort_i = 1'b0; din_vld_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_stat", {29'd0, crc_ok_o, crc_err_o, frm_err_o}, 32'd0);
        repeat (5) tick();
        // Start together with abort is ignored.
        start_i = 1'b1; abort_i = 1'b1; blk_len_i = 10'd1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("abort_start_busy", 32'(busy_o), 32'd0);
        repeat (2) tick();
        basic_block(16'h1021, 1'b1, 0);

        // Reset for one cycle in the middle of the CRC phase.
        do_start(1);
        send_bit(1'b0, 0);
        for (int k = 7; k >= 0; k--) send_bit(k == 0, 0);
        for (int k = 15; k >= 11; k--) send_bit(1'b0, 0);
        din_vld_i = 1'b1; din_i = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_outs", {busy_o, done_o, crc_ok_o, crc_err_o, frm_err_o, crc_calc_o, crc_rcvd_o}, 32'd0);
        din_vld_i = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy_o), 32'd0);
        repeat (5) send_bit(1'b1, 0);
        chk("midrst_idle", 32'(busy_o), 32'd0);
        basic_block(16'h1021, 1'b1, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
